exec_stage: RTL and testbench
=============================

# exec_stage

Execute stage of the multicycle processor pipeline, directly downstream of the decode/execute pipeline register. It consumes that register's operands, destination register, immediate and PC. It computes a single-cycle ALU result, or an iterative 32-cycle multiply that stalls upstream. The result is captured into the execute/memory pipeline register, which this block owns.

## Interface

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  downstream advance enable; output register loads only when high
- flush_i  in  1  synchronous kill of the instruction in this stage
- valid_i  in  1  instruction present; low means bubble
- alu_op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10–15 yield 0
- alu_src_i  in  1  1 selects SignImm as operand B, 0 selects SrcB
- SrcAE, SrcBE, SignImm, WriteDataE, pcDE  in  32 each  from decode/execute register
- WriteRegE  in  5  destination register
- stall_o  out  1  upstream must hold its inputs (freeze decode/execute register)
- ALUOutM, WriteDataM, pcEM  out  32 each  registered results
- WriteRegM  out  5  registered destination
- validM  out  1  registered valid

## Operation

- B = alu_src_i ? SignImm : SrcBE. Shifts use B[4:0]. SRA is arithmetic. SLT gives 1/0 on signed compare. All arithmetic wraps modulo 2^32.
- FSM states: IDLE, MUL, DONE. `start` = IDLE & valid_i & alu_op_i==9 & ~flush_i.
- IDLE, non-MUL op: stall_o=0. On the edge with en_i=1, load {ALUOutM, WriteDataM, WriteRegM, pcEM, validM} from the combinational result.
- IDLE & start: stall_o=1. On the next edge, load mcand=SrcAE, mplier=B, acc=0, cnt=0, and go to MUL. The output register is not loaded.
- MUL: stall_o=1. Each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt += 1. When cnt==31 is processed, go to DONE. Iteration proceeds regardless of en_i.
- DONE: stall_o=0. ALUOutM = acc (low 32 bits of the product). On the edge with en_i=1, load the output register and go to IDLE. DONE holds while en_i=0.
- Bubble (valid_i=0) or flush_i=1 when loading: validM=0; ALUOutM, WriteDataM, WriteRegM = 0; pcEM = pcDE.
- flush_i in MUL or DONE: return to IDLE next edge, and discard acc. A bubble loads if en_i=1. stall_o drops combinationally in the flush cycle.
- The output register holds all values whenever en_i=0.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE, acc/mcand/mplier/cnt=0. All outputs 0: ALUOutM, WriteDataM, pcEM, WriteRegM, validM = 0. stall_o=0.
- Reset mid-multiply aborts it with no output effect. The first edge after release behaves as IDLE.
- ALU ops: 1-cycle latency, result visible after the edge on which en_i=1.
- MUL: instruction occupies the stage for 34 cycles (1 start + 32 iterate + 1 DONE) with en_i=1 throughout. stall_o is high for the first 33 cycles. The result is visible after the 34th edge.
- Upstream advances on the same edge that DONE loads the output register. The next instruction is presented the following cycle.
- Back-to-back MULs: the second start occurs in the cycle after DONE, with no lost cycles.
- Simultaneous flush_i and start: flush wins, no multiply starts, and a bubble loads.

## Test plan

- Reset, then ADD with SrcAE=5, SrcBE=7, alu_src=0, WriteRegE=3, en_i=1 -> one edge later ALUOutM=12, WriteRegM=3, validM=1, stall_o stayed 0.
- SUB and SLT with immediate: SrcAE=0x00000001, SignImm=0xFFFFFFFF, alu_src=1 -> SUB gives 0x00000002. SLT gives 0 (1 > -1). SRA of 0x80000000 by 4 gives 0xF8000000.
- MUL SrcAE=7, SrcBE=6 -> stall_o high exactly 33 cycles. ALUOutM=42, validM=1 after the 34th edge. MUL 0xFFFFFFFF×3 -> 0xFFFFFFFD.
- MUL with en_i dropped low in MUL and DONE for 5 cycles -> the result is still 42. The output register is unchanged until en_i returns. No extra iterations are applied.
- flush_i pulsed at iteration 10 of a MUL -> stall_o=0 that cycle. The next edge loads validM=0, ALUOutM=0, pcEM=pcDE. The following ADD executes normally.
- rst_n asserted asynchronously mid-MUL (between edges) -> all outputs 0 immediately. After release, a new MUL 2×2 yields 4 with standard 34-cycle timing.

Source files
------------

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-and-add multiplier,
// feeding the execute/memory pipeline register owned by this block.
module exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [3:0]      alu_op_i,
    input  logic            alu_src_i,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [XLEN-1:0] SignImm,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] pcDE,
    input  logic [4:0]      WriteRegE,
    output logic            stall_o,
    output logic [XLEN-1:0] ALUOutM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] pcEM,
    output logic [4:0]      WriteRegM,
    output logic            validM
);

    localparam int SHW = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] mcand_reg;
    logic [XLEN-1:0] mplier_reg;
    logic [4:0]      cnt_reg;

    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic            start;
    logic            kill;
    logic            load_en;
    logic [XLEN-1:0] alu_out_next;
    logic [XLEN-1:0] write_data_next;
    logic [4:0]      write_reg_next;
    logic            valid_next;

    assign operand_b = alu_src_i ? SignImm : SrcBE;
    assign start     = (state_reg == IDLE) && valid_i && (alu_op_i == OP_MUL) && !flush_i;

    // ---------------------------------------------------------------
    // Barrel shifter: one right-shifting log stage per shift-amount bit.
    // Left shifts reuse it by bit-reversing operand and result.
    // ---------------------------------------------------------------
    logic            shift_left;
    logic            shift_fill;
    logic [XLEN-1:0] src_a_rev;
    logic [XLEN-1:0] shift_rev;
    logic [XLEN-1:0] shift_stage [0:SHW];

    assign shift_left = (alu_op_i == OP_SLL);
    assign shift_fill = (alu_op_i == OP_SRA) && SrcAE[XLEN-1];

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_rev
            assign src_a_rev[gi] = SrcAE[XLEN-1-gi];
            assign shift_rev[gi] = shift_stage[SHW][XLEN-1-gi];
        end

        assign shift_stage[0] = shift_left ? src_a_rev : SrcAE;

        for (gi = 0; gi < SHW; gi++) begin : g_shift
            assign shift_stage[gi+1] = operand_b[gi]
                ? {{(1 << gi){shift_fill}}, shift_stage[gi][XLEN-1:(1 << gi)]}
                : shift_stage[gi];
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        case (alu_op_i)
            OP_ADD: alu_result = SrcAE + operand_b;
            OP_SUB: alu_result = SrcAE - operand_b;
            OP_AND: alu_result = SrcAE & operand_b;
            OP_OR:  alu_result = SrcAE | operand_b;
            OP_XOR: alu_result = SrcAE ^ operand_b;
            OP_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(SrcAE) < $signed(operand_b))};
            OP_SLL: alu_result = shift_rev;
            OP_SRL: alu_result = shift_stage[SHW];
            OP_SRA: alu_result = shift_stage[SHW];
            default: alu_result = '0;
        endcase
    end

    // Bubbles and killed instructions still forward the PC.
    assign kill            = !valid_i || flush_i;
    assign alu_out_next    = kill ? '0 : ((state_reg == DONE) ? acc_reg : alu_result);
    assign write_data_next = kill ? '0 : WriteDataE;
    assign write_reg_next  = kill ? 5'd0 : WriteRegE;
    assign valid_next      = !kill;

    always_comb begin
        load_en = 1'b0;
        case (state_reg)
            IDLE:    load_en = en_i && !start;
            MUL:     load_en = en_i && flush_i;
            DONE:    load_en = en_i;
            default: load_en = 1'b0;
        endcase
    end

    // Reset also forces stall low while the FSM is being cleared.
    always_comb begin
        stall_o = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE:    stall_o = start;
                MUL:     stall_o = !flush_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            pcEM       <= '0;
            WriteRegM  <= '0;
            validM     <= 1'b0;
        end else begin
            if (load_en) begin
                ALUOutM    <= alu_out_next;
                WriteDataM <= write_data_next;
                pcEM       <= pcDE;
                WriteRegM  <= write_reg_next;
                validM     <= valid_next;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= SrcAE;
                        mplier_reg <= operand_b;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= MUL;
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        acc_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        if (mplier_reg[0]) begin
                            acc_reg <= acc_reg + mcand_reg;
                        end
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush_i) begin
                        acc_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (en_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Randomized self-checking bench for exec_stage; expected results come from a
// transaction-level model (plain arithmetic plus cycle counts).
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        flush_i;
    logic        valid_i;
    logic [3:0]  alu_op_i;
    logic        alu_src_i;
    logic [31:0] SrcAE, SrcBE, SignImm, WriteDataE, pcDE;
    logic [4:0]  WriteRegE;
    logic        stall_o;
    logic [31:0] ALUOutM, WriteDataM, pcEM;
    logic [4:0]  WriteRegM;
    logic        validM;

    always #5 clk = ~clk;

    exec_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .alu_op_i   (alu_op_i),
        .alu_src_i  (alu_src_i),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .SignImm    (SignImm),
        .WriteDataE (WriteDataE),
        .pcDE       (pcDE),
        .WriteRegE  (WriteRegE),
        .stall_o    (stall_o),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .pcEM       (pcEM),
        .WriteRegM  (WriteRegM),
        .validM     (validM)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the execute/memory register contents.
    logic [31:0] exp_alu, exp_wd, exp_pc;
    logic [4:0]  exp_wr;
    logic        exp_v;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a << b[4:0];
            4'd7: r = a >> b[4:0];
            4'd8: r = $signed(a) >>> b[4:0];
            4'd9: r = a * b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check_value({tag, ".alu"}, ALUOutM, exp_alu);
        check_value({tag, ".wd"},  WriteDataM, exp_wd);
        check_value({tag, ".wr"},  {27'd0, WriteRegM}, {27'd0, exp_wr});
        check_value({tag, ".pc"},  pcEM, exp_pc);
        check_value({tag, ".v"},   {31'd0, validM}, {31'd0, exp_v});
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc, input logic v, input logic fl);
        alu_op_i = op; SrcAE = a; SrcBE = b; SignImm = imm; alu_src_i = src;
        WriteDataE = wd; WriteRegE = rd; pcDE = pc; valid_i = v; flush_i = fl;
    endtask

    // One single-cycle instruction; called at a falling edge, returns at the next.
    task automatic do_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src, input logic [4:0] rd,
                          input logic v, input logic fl, input logic en);
        logic [31:0] wd, pc;
        wd = $urandom;
        pc = $urandom;
        drive(op, a, b, imm, src, wd, rd, pc, v, fl);
        en_i = en;
        #1 check_value("alu_stall", {31'd0, stall_o}, 32'd0);
        if (en) begin
            if (v && !fl) begin
                exp_alu = ref_alu(op, a, src ? imm : b);
                exp_wd  = wd;
                exp_wr  = rd;
                exp_v   = 1'b1;
            end else begin
                exp_alu = 32'd0; exp_wd = 32'd0; exp_wr = 5'd0; exp_v = 1'b0;
            end
            exp_pc = pc;
        end
        @(negedge clk);
        check_outputs("alu");
        $display("alu op=%0d a=%08h b=%08h src=%0d v=%0d fl=%0d en=%0d -> %08h", op, a, b, src, v, fl, en, ALUOutM);
    endtask

    // Multiply; en_i drops for n_hold cycles inside MUL and again inside DONE.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic src, input int n_hold);
        logic [31:0] wd, pc;
        logic [4:0]  rd;
        int total;
        wd = $urandom;
        pc = $urandom;
        rd = 5'($urandom);
        total = 34 + n_hold;
        drive(4'd9, a, b, imm, src, wd, rd, pc, 1'b1, 1'b0);
        for (int c = 0; c < total; c++) begin
            en_i = !((c >= 10 && c < 10 + n_hold) || (c >= 33 && c < 33 + n_hold));
            #1 check_value("mul_stall", {31'd0, stall_o}, (c < 33) ? 32'd1 : 32'd0);
            @(negedge clk);
            if (c < total - 1) begin
                check_value("mul_hold.alu", ALUOutM, exp_alu);
                check_value("mul_hold.v", {31'd0, validM}, {31'd0, exp_v});
            end
        end
        exp_alu = ref_alu(4'd9, a, src ? imm : b);
        exp_wd = wd; exp_wr = rd; exp_pc = pc; exp_v = 1'b1;
        check_outputs("mul");
        $display("mul a=%08h b=%08h hold=%0d -> %08h", a, src ? imm : b, n_hold, ALUOutM);
    endtask

    // Multiply killed by flush_i in cycle fcyc (cycle 0 is the start cycle).
    task automatic mul_flush(input logic [31:0] a, input logic [31:0] b, input int fcyc);
        logic [31:0] pc;
        pc = $urandom;
        drive(4'd9, a, b, 32'd0, 1'b0, $urandom, 5'd7, pc, 1'b1, 1'b0);
        en_i = 1'b1;
        for (int c = 0; c < fcyc; c++) begin
            #1 check_value("flush_pre_stall", {31'd0, stall_o}, (c < 33) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        flush_i = 1'b1;
        #1 check_value("flush_stall", {31'd0, stall_o}, 32'd0);
        exp_alu = 32'd0; exp_wd = 32'd0; exp_wr = 5'd0; exp_pc = pc; exp_v = 1'b0;
        @(negedge clk);
        check_outputs("flush");
        flush_i = 1'b0;
        $display("mul_flush at cycle %0d -> v=%0d pc=%08h", fcyc, validM, pcEM);
    endtask

    initial begin
        logic [3:0] op;
        logic       v, fl, en;

        rst_n = 1'b0;
        en_i = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_alu = 0; exp_wd = 0; exp_wr = 0; exp_pc = 0; exp_v = 0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check_value("reset_stall", {31'd0, stall_o}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_alu(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        check_value("add_lit", ALUOutM, 32'd12);
        do_alu(4'd1, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        check_value("sub_lit", ALUOutM, 32'h2);
        do_alu(4'd5, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        check_value("slt_lit", ALUOutM, 32'h0);
        do_alu(4'd8, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        check_value("sra_lit", ALUOutM, 32'hF800_0000);
        do_alu(4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // en low: hold
        do_alu(4'd9, 32'd3, 32'd3, 32'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);   // flush beats start
        do_alu(4'd12, 32'd3, 32'd3, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);  // reserved op

        do_mul(32'd7, 32'd6, 32'd0, 1'b0, 0);
        check_value("mul_lit", ALUOutM, 32'd42);
        do_mul(32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 0);   // back-to-back
        check_value("mul_wrap_lit", ALUOutM, 32'hFFFF_FFFD);
        do_mul(32'd7, 32'd6, 32'd0, 1'b0, 5);
        check_value("mul_hold_lit", ALUOutM, 32'd42);

        mul_flush(32'd7, 32'd6, 11);
        do_alu(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
        mul_flush(32'd5, 32'd5, 33);   // flush while in DONE
        do_alu(4'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 6) != 0);
            if (op == 4'd9 && v && !fl) op = 4'd10;
            do_alu(op, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), v, fl, en);
        end
        for (int i = 0; i < 5; i++) begin
            do_mul($urandom, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a multiply
        drive(4'd9, 32'd11, 32'd13, 32'd0, 1'b0, 32'h55, 5'd2, 32'h40, 1'b1, 1'b0);
        en_i = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_alu = 0; exp_wd = 0; exp_wr = 0; exp_pc = 0; exp_v = 0;
        check_outputs("async_rst");
        check_value("async_rst_stall", {31'd0, stall_o}, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(32'd2, 32'd2, 32'd0, 1'b0, 0);
        check_value("post_rst_mul_lit", ALUOutM, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
